fil_frame_bridge: RTL and testbench
===================================

FIL_FRAME_BRIDGE -- requirements
Module: fil_frame_bridge

Interface
REQ-001 The block SHALL have parameter NUM_IN_CH, default 4, giving the number of DUT input channels.
REQ-002 The block SHALL have parameter IN_W, default 18, giving the bits per input channel.
REQ-003 The block SHALL have parameter NUM_OUT_CH, default 8, giving the number of DUT output channels.
REQ-004 The block SHALL have parameter OUT_W, default 16, giving the bits per output channel.
REQ-005 The block SHALL have parameter DUT_LAT, default 1 (range 1..15), giving the cycles from dut_enb to valid dut outputs.
REQ-006 Derived widths SHALL be: ISB = ceil(IN_W/8), OSB = ceil(OUT_W/8), IFB = NUM_IN_CH*ISB bytes (default 12), OFB = 1+NUM_OUT_CH*OSB bytes (default 17).
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
s_data  in  8  input byte stream
s_valid  in  1  input byte valid
s_last  in  1  input frame end marker
s_ready  out  1  input byte accepted when s_valid && s_ready
m_data  out  8  output byte stream
m_valid  out  1  output byte valid
m_last  out  1  last byte of output frame
m_ready  in  1  downstream accepts byte
dut_din  out  NUM_IN_CH*IN_W  channel k at bits [k*IN_W +: IN_W]
dut_enb  out  1  DUT clock-enable step pulse
dut_ce_out  in  1  DUT clock-enable echo
dut_dout  in  NUM_OUT_CH*OUT_W  channel k at bits [k*OUT_W +: OUT_W]
frame_err_cnt  out  8  framing error count, saturating
busy  out  1  high in every state except RX

Function
REQ-008 The FSM SHALL have states RX, DRAIN, STEP, WAIT and TX.
REQ-009 s_ready SHALL be 1 in RX and DRAIN and 0 in all other states.
REQ-010 In RX, accepted bytes SHALL fill the shadow frame little-endian, channel 0 first; slot bits at or above IN_W SHALL be discarded.
REQ-011 When byte IFB-1 is accepted with s_last=1, the FSM SHALL go to STEP.
REQ-012 When s_last=1 is accepted at byte index < IFB-1, the frame SHALL be discarded, frame_err_cnt SHALL increment, and the FSM SHALL stay in RX with the index cleared.
REQ-013 When byte IFB-1 is accepted with s_last=0, frame_err_cnt SHALL increment and the FSM SHALL go to DRAIN.
REQ-014 DRAIN SHALL discard bytes until a byte with s_last=1 is accepted, then go to RX; bytes consumed in DRAIN SHALL NOT increment the counter further.
REQ-015 frame_err_cnt SHALL saturate at 255.
REQ-016 dut_din SHALL load from the shadow frame only on entry to STEP; it SHALL hold its previous value otherwise, including after discarded frames.
REQ-017 STEP SHALL last one cycle with dut_enb=1; dut_din SHALL already hold the new frame in that cycle. dut_enb SHALL be 0 in all other states.
REQ-018 WAIT SHALL count DUT_LAT cycles; on its last cycle (DUT_LAT cycles after the STEP cycle) dut_dout and dut_ce_out SHALL be captured into the output frame, and the FSM SHALL enter TX.
REQ-019 Latency: if the last input byte is accepted in cycle T, dut_enb SHALL be high in T+1 and m_valid SHALL first rise in T+2+DUT_LAT.
REQ-020 Output frame byte 0 SHALL be {seq[6:0], captured ce_out}.
REQ-021 Output channel slots SHALL follow byte 0, little-endian, channel 0 first, with bits above OUT_W zero-filled.
REQ-022 In TX, m_valid SHALL be 1 and m_data/m_last SHALL be held stable while m_valid && !m_ready.
REQ-023 m_last SHALL be 1 only on byte OFB-1.
REQ-024 After the final handshake the FSM SHALL return to RX, and seq SHALL increment modulo 128, wrapping 127->0.
REQ-025 s_valid activity outside RX/DRAIN SHALL be ignored, with no byte consumed.

Reset
REQ-026 While reset=0: state=RX, byte index=0, seq=0, dut_din=0, dut_enb=0, s_ready=1 (once reset deasserts), m_valid=0, m_last=0, m_data=0, frame_err_cnt=0, busy=0, and the shadow and capture registers SHALL be 0.
REQ-027 Reset asserted mid-frame (RX, WAIT or TX) SHALL abandon the frame immediately with no further m_valid or dut_enb, and the next frame SHALL start at byte index 0 with seq=0.

Verification
REQ-028 Good frame, defaults, DUT_LAT=1: bytes FF FF FF, 01 00 00, 00 00 02, 34 12 00 (last on byte 12) -> dut_din ch0=0x3FFFF, ch1=0x00001, ch2=0x20000, ch3=0x01234; one dut_enb pulse; with dut_ce_out=1 and dut_dout ch k = 0x1000+k, the output is 17 bytes: 01, 00 10, 01 10, ..., 07 10, with m_last on byte 17.
REQ-029 Short frame: s_last on byte 5 -> frame_err_cnt=1, no dut_enb, dut_din unchanged; the next good frame is processed normally.
REQ-030 Missing last: 12 bytes then 3 more, s_last on byte 15 -> frame_err_cnt=1, DRAIN consumes bytes 13-15, no dut_enb.
REQ-031 Backpressure: m_ready low for 5 cycles on output byte 3 -> m_data held constant, no byte lost or duplicated, and s_ready=0 throughout TX.
REQ-032 Wrap/saturation: 129 good frames -> status byte of frame 129 has seq=0; 300 short frames -> frame_err_cnt=255.
REQ-033 Reset during TX byte 8 -> m_valid=0 within the same cycle, seq=0, and the following good frame emits status byte seq=0.

Source files
------------

// File: rtl/fil_frame_bridge.sv
// Frame bridge for FPGA-in-the-loop: unpacks an input byte frame onto the DUT channels,
// steps the DUT once, then streams the status byte and captured channel outputs back out.
module fil_frame_bridge #(
    parameter int NUM_IN_CH  = 4,
    parameter int IN_W       = 18,
    parameter int NUM_OUT_CH = 8,
    parameter int OUT_W      = 16,
    parameter int DUT_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [7:0]                  m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [NUM_IN_CH*IN_W-1:0]   dut_din,
    output logic                        dut_enb,
    input  logic                        dut_ce_out,
    input  logic [NUM_OUT_CH*OUT_W-1:0] dut_dout,
    output logic [7:0]                  frame_err_cnt,
    output logic                        busy
);
    localparam int ISB   = (IN_W + 7) / 8;
    localparam int OSB   = (OUT_W + 7) / 8;
    localparam int IFB   = NUM_IN_CH * ISB;
    localparam int OFB   = 1 + NUM_OUT_CH * OSB;
    localparam int OSW   = OSB * 8;
    localparam int DIN_W = NUM_IN_CH * IN_W;
    localparam int IDX_W = $clog2(IFB + 1);
    localparam int TX_W  = $clog2(OFB + 1);
    localparam logic [IDX_W-1:0] IN_LAST   = IDX_W'(IFB - 1);
    localparam logic [TX_W-1:0]  TX_LAST   = TX_W'(OFB - 1);
    localparam logic [3:0]       WAIT_LAST = 4'(DUT_LAT - 1);

    typedef enum logic [2:0] {ST_RX, ST_DRAIN, ST_STEP, ST_WAIT, ST_TX} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     in_idx_reg, in_idx_next;
    logic [TX_W-1:0]      tx_idx_reg, tx_idx_next;
    logic [3:0]           wait_cnt_reg, wait_cnt_next;
    logic [6:0]           seq_reg, seq_next;
    logic [7:0]           err_reg, err_next;
    logic                 err_inc;
    logic [DIN_W-1:0]     shadow_reg, shadow_next, shadow_wr;
    logic [DIN_W-1:0]     din_reg, din_next;
    logic [OFB*8-1:0]     cap_reg, cap_next, cap_frame;
    logic [NUM_OUT_CH*OSW-1:0] dout_pad;

    // Shadow frame with the current byte merged in; slot bits at or above IN_W are never stored.
    for (genvar gi = 0; gi < NUM_IN_CH; gi++) begin : g_in_ch
        for (genvar bi = 0; bi < ISB; bi++) begin : g_in_byte
            localparam int LSB = gi * IN_W + bi * 8;
            localparam int BW  = (IN_W - bi * 8 < 8) ? IN_W - bi * 8 : 8;
            localparam logic [IDX_W-1:0] POS = IDX_W'(gi * ISB + bi);
            assign shadow_wr[LSB +: BW] = (in_idx_reg == POS) ? s_data[BW-1:0]
                                                              : shadow_reg[LSB +: BW];
        end
    end

    for (genvar gi = 0; gi < NUM_OUT_CH; gi++) begin : g_out_ch
        assign dout_pad[gi*OSW +: OSW] = OSW'(dut_dout[gi*OUT_W +: OUT_W]);
    end
    assign cap_frame = {dout_pad, seq_reg, dut_ce_out};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RX;
            in_idx_reg   <= '0;
            tx_idx_reg   <= '0;
            wait_cnt_reg <= '0;
            seq_reg      <= '0;
            err_reg      <= '0;
            shadow_reg   <= '0;
            din_reg      <= '0;
            cap_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            in_idx_reg   <= in_idx_next;
            tx_idx_reg   <= tx_idx_next;
            wait_cnt_reg <= wait_cnt_next;
            seq_reg      <= seq_next;
            err_reg      <= err_next;
            shadow_reg   <= shadow_next;
            din_reg      <= din_next;
            cap_reg      <= cap_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        in_idx_next   = in_idx_reg;
        tx_idx_next   = tx_idx_reg;
        wait_cnt_next = wait_cnt_reg;
        seq_next      = seq_reg;
        shadow_next   = shadow_reg;
        din_next      = din_reg;
        cap_next      = cap_reg;
        err_inc       = 1'b0;
        dut_enb       = 1'b0;
        m_valid       = 1'b0;
        m_data        = 8'h00;
        m_last        = 1'b0;
        case (state_reg)
            ST_RX: begin
                if (s_valid) begin
                    shadow_next = shadow_wr;
                    if (s_last) begin
                        in_idx_next = '0;
                        if (in_idx_reg == IN_LAST) begin
                            din_next   = shadow_wr;
                            state_next = ST_STEP;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (in_idx_reg == IN_LAST) begin
                        in_idx_next = '0;
                        err_inc     = 1'b1;
                        state_next  = ST_DRAIN;
                    end else begin
                        in_idx_next = in_idx_reg + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) state_next = ST_RX;
            end
            ST_STEP: begin
                dut_enb       = 1'b1;
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    cap_next    = cap_frame;
                    tx_idx_next = '0;
                    state_next  = ST_TX;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_TX: begin
                m_valid = 1'b1;
                m_data  = cap_reg[{tx_idx_reg, 3'b000} +: 8];
                m_last  = (tx_idx_reg == TX_LAST);
                if (m_ready) begin
                    if (tx_idx_reg == TX_LAST) begin
                        tx_idx_next = '0;
                        seq_next    = seq_reg + 1'b1;
                        state_next  = ST_RX;
                    end else begin
                        tx_idx_next = tx_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_RX;
        endcase
    end

    assign err_next      = (err_inc && err_reg != 8'hFF) ? err_reg + 1'b1 : err_reg;
    assign s_ready       = (state_reg == ST_RX) || (state_reg == ST_DRAIN);
    assign busy          = (state_reg != ST_RX);
    assign dut_din       = din_reg;
    assign frame_err_cnt = err_reg;
endmodule

// File: tb/tb_fil_frame_bridge.sv
// Bench for fil_frame_bridge: table of input frames plus sequences for backpressure,
// reset mid-frame, sequence wrap and error-count saturation; outputs checked via a scoreboard.
module tb_fil_frame_bridge;
    localparam int NUM_IN_CH  = 4;
    localparam int IN_W       = 18;
    localparam int NUM_OUT_CH = 8;
    localparam int OUT_W      = 16;
    localparam int DUT_LAT    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [NUM_IN_CH*IN_W-1:0]   dut_din;
    logic        dut_enb;
    logic        dut_ce_out = 1'b0;
    logic [NUM_OUT_CH*OUT_W-1:0] dut_dout = '0;
    logic [7:0]  frame_err_cnt;
    logic        busy;

    fil_frame_bridge #(
        .NUM_IN_CH(NUM_IN_CH), .IN_W(IN_W), .NUM_OUT_CH(NUM_OUT_CH),
        .OUT_W(OUT_W), .DUT_LAT(DUT_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .dut_din(dut_din), .dut_enb(dut_enb), .dut_ce_out(dut_ce_out), .dut_dout(dut_dout),
        .frame_err_cnt(frame_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           nbytes;
        int           last_at;
        logic [119:0] bytes;
        logic         good;
        logic         ce;
        logic [15:0]  dout_base;
        logic [71:0]  exp_din;
    } vec_t;
    vec_t vecs[6];

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] sb[$];
    logic [8:0] sb_exp;
    logic [6:0] exp_seq = 7'd0;
    int         exp_err = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         enb_cyc = 0;
    int         mv_cyc = 0;
    int         enb_cnt = 0;
    int         popped = 0;
    logic       mv_prev = 1'b0;
    logic       hold_prev = 1'b0;
    logic [8:0] hold_val = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (s_valid && s_ready && s_last) last_acc_cyc = cyc;
            if (dut_enb) begin
                enb_cnt++;
                enb_cyc = cyc;
            end
            if (m_valid && !mv_prev) mv_cyc = cyc;
            if (m_valid) check("s_ready_in_tx", s_ready, 0);
            if (hold_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", {m_last, m_data}, hold_val);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: got byte %0h, expected no output", m_data);
                end else begin
                    sb_exp = sb.pop_front();
                    check("out_byte", {m_last, m_data}, sb_exp);
                end
                popped++;
            end
            mv_prev   = m_valid;
            hold_prev = m_valid && !m_ready;
            hold_val  = {m_last, m_data};
        end else begin
            mv_prev   = 1'b0;
            hold_prev = 1'b0;
        end
    end

    task automatic set_dout(input logic ce, input logic [15:0] base);
        logic [15:0] v;
        dut_ce_out = ce;
        for (int k = 0; k < NUM_OUT_CH; k++) begin
            v = base + 16'(k);
            dut_dout[k*OUT_W +: OUT_W] = v;
        end
    endtask

    task automatic push_expected(input logic ce, input logic [15:0] base);
        logic [15:0] v;
        sb.push_back({1'b0, exp_seq, ce});
        for (int k = 0; k < NUM_OUT_CH; k++) begin
            v = base + 16'(k);
            sb.push_back({1'b0, v[7:0]});
            sb.push_back({k == NUM_OUT_CH - 1, v[15:8]});
        end
        exp_seq = exp_seq + 7'd1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        s_data  = b;
        s_valid = 1'b1;
        s_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                check("s_ready_timeout", s_ready, 1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: got busy=%0d pending=%0d, expected idle", name, busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        exp_seq = 7'd0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_vec(input int i);
        int e0;
        set_dout(vecs[i].ce, vecs[i].dout_base);
        e0 = enb_cnt;
        if (vecs[i].good) push_expected(vecs[i].ce, vecs[i].dout_base);
        for (int j = 0; j < vecs[i].nbytes; j++)
            send_byte(vecs[i].bytes[j*8 +: 8], (j + 1) == vecs[i].last_at);
        wait_idle("vec");
        if (!vecs[i].good) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        check("err_cnt", frame_err_cnt, exp_err);
        check("enb_pulses", enb_cnt - e0, vecs[i].good ? 1 : 0);
        check("dut_din", dut_din, vecs[i].exp_din);
        if (vecs[i].good) begin
            check("lat_enb", enb_cyc - last_acc_cyc, 1);
            check("lat_mvalid", mv_cyc - last_acc_cyc, 2 + DUT_LAT);
        end
        $display("vec %0d: bytes=%0d last_at=%0d err_cnt=%0d din=%0h", i, vecs[i].nbytes,
                 vecs[i].last_at, frame_err_cnt, dut_din);
    endtask

    initial begin
        int         n;
        int         base_pop;
        logic [7:0] d0;

        vecs[0] = '{12, 12, 120'h00_12_34_02_00_00_00_00_01_FF_FF_FF, 1'b1, 1'b1, 16'h1000,
                    {18'h01234, 18'h20000, 18'h00001, 18'h3FFFF}};
        vecs[1] = '{5, 5, 120'h55_44_33_22_11, 1'b0, 1'b0, 16'h0000,
                    {18'h01234, 18'h20000, 18'h00001, 18'h3FFFF}};
        vecs[2] = '{12, 12, 120'h56_34_12_00_00_FF_03_55_AA_00_00_00, 1'b1, 1'b0, 16'hABF0,
                    {18'h23412, 18'h000FF, 18'h355AA, 18'h00000}};
        vecs[3] = '{15, 15, {15{8'h77}}, 1'b0, 1'b0, 16'h0000,
                    {18'h23412, 18'h000FF, 18'h355AA, 18'h00000}};
        vecs[4] = '{12, 12, 120'h0C_0B_0A_09_08_07_06_05_04_03_02_01, 1'b1, 1'b1, 16'hFFF8,
                    {18'h00B0A, 18'h10807, 18'h20504, 18'h30201}};
        vecs[5] = '{1, 1, 120'h99, 1'b0, 1'b1, 16'h0000,
                    {18'h00B0A, 18'h10807, 18'h20504, 18'h30201}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_dut_enb", dut_enb, 0);
        check("rst_dut_din", dut_din, 0);
        check("rst_err_cnt", frame_err_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 1);
        $display("reset: state checked");

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure on output byte 3
        m_ready = 1'b0;
        set_dout(1'b0, 16'h5550);
        push_expected(1'b0, 16'h5550);
        for (int j = 0; j < 12; j++) send_byte(vecs[2].bytes[j*8 +: 8], j == 11);
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid_seen", m_valid, 1);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b0;
        d0 = m_data;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", m_data, d0);
            check("bp_hold_valid", m_valid, 1);
            check("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        wait_idle("bp");
        $display("backpressure: held byte %0h for 5 cycles", d0);

        // Reset during output byte 8
        set_dout(1'b1, 16'h2000);
        push_expected(1'b1, 16'h2000);
        base_pop = popped;
        for (int j = 0; j < 12; j++) send_byte(vecs[0].bytes[j*8 +: 8], j == 11);
        n = 0;
        while ((popped - base_pop) < 7 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_tx_reached", popped - base_pop, 7);
        reset = 1'b0;
        #1;
        check("rst_tx_m_valid", m_valid, 0);
        check("rst_tx_dut_enb", dut_enb, 0);
        check("rst_tx_busy", busy, 0);
        check("rst_tx_err_cnt", frame_err_cnt, 0);
        check("rst_tx_m_data", m_data, 0);
        check("rst_tx_dut_din", dut_din, 0);
        sb.delete();
        exp_seq = 7'd0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_hold_m_valid", m_valid, 0);
        reset = 1'b1;
        $display("reset during TX after %0d bytes", popped - base_pop);
        run_vec(2);

        // Reset in the middle of an input frame
        for (int j = 0; j < 5; j++) send_byte(vecs[4].bytes[j*8 +: 8], 1'b0);
        do_reset();
        run_vec(4);

        // Sequence wrap over 129 frames
        do_reset();
        for (int f = 0; f < 129; f++) run_vec(0);

        // Error counter saturation
        n = enb_cnt;
        for (int f = 0; f < 300; f++) begin
            send_byte(8'h5A, 1'b1);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        @(negedge clk);
        check("err_saturate", frame_err_cnt, exp_err);
        check("sat_no_enb", enb_cnt - n, 0);
        $display("saturation: err_cnt=%0d", frame_err_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
